io_writeback: RTL
=================

IO_WRITEBACK -- requirements
Module: io_writeback

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000, giving the I/O wait limit in cycles (used only with IO_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port alu_out  in  16  ALU result.
REQ-005 SHALL have port alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flags.
REQ-006 SHALL have port input_flag, output_flag, halt_flag, szcv_write_flag, ird_write_flag  in  1 each  ALU control flags, already gated by instruction validity.
REQ-007 SHALL have port rd_addr  in  3  destination register index.
REQ-008 SHALL have port op_data  in  16  register value to emit on OUT.
REQ-009 SHALL have ports in_data  in  16, in_valid  in  1 and in_ready  out  1, forming the input-device handshake.
REQ-010 SHALL have ports out_data  out  16, out_valid  out  1 and out_ready  in  1, forming the output-device handshake.
REQ-011 SHALL have ports wb_en  out  1, wb_addr  out  3 and wb_data  out  16, forming the register-file write port.
REQ-012 SHALL have ports szcv  out  4 {S,Z,C,V}, stall  out  1, halted  out  1 and io_timeout  out  1.

Function
REQ-013 SHALL implement FSM states IDLE, OUT_WAIT, IN_WAIT and HALTED.
REQ-014 SHALL evaluate flags in IDLE with priority halt_flag > output_flag > input_flag > plain.
REQ-015 On a plain instruction in IDLE, SHALL register wb_en=ird_write_flag, wb_addr=rd_addr and wb_data=alu_out, visible the next cycle, asserted for exactly 1 cycle.
REQ-016 On a plain instruction in IDLE with szcv_write_flag=1, SHALL register szcv={alu_s,alu_z,alu_c,alu_v} on the same edge as the writeback.
REQ-017 On output_flag in IDLE, SHALL latch out_data=op_data and go to OUT_WAIT; szcv and register-file writeback SHALL NOT be performed.
REQ-018 In OUT_WAIT, SHALL hold out_valid=1 and out_data stable until the cycle where out_valid&out_ready, then return to IDLE with out_valid=0 on the next cycle.
REQ-019 On input_flag in IDLE, SHALL latch rd_addr and go to IN_WAIT with in_ready=1.
REQ-020 In IN_WAIT, on in_valid&in_ready SHALL, next cycle, pulse wb_en for 1 cycle with wb_data=in_data, set szcv={in_data[15], in_data==0, 0, 0}, drop in_ready, and return to IDLE.
REQ-021 On halt_flag in IDLE, SHALL enter HALTED, the terminal state until reset; halted=1.
REQ-022 SHALL drive stall=1 whenever state is not IDLE (combinational from state); all ALU flags SHALL be ignored while stall=1.
REQ-023 in_ready SHALL be 1 only in IN_WAIT; out_valid SHALL be 1 only in OUT_WAIT.
REQ-024 A device asserting in_valid outside IN_WAIT SHALL have no effect.

Reset
REQ-025 While rst_n=0, SHALL be in state IDLE with wb_en=0, wb_addr=0, wb_data=0, szcv=0, out_valid=0, out_data=0, in_ready=0, stall=0, halted=0 and io_timeout=0.
REQ-026 Reset asserted mid-handshake SHALL abort it immediately; no writeback or output transfer SHALL complete.

Configuration
REQ-027 With IO_TIMEOUT_EN defined, a counter SHALL count cycles spent in OUT_WAIT/IN_WAIT; after TIMEOUT_CYC cycles without a handshake, it SHALL return to IDLE with no writeback and set io_timeout sticky high until reset.
REQ-028 Without IO_TIMEOUT_EN, waits SHALL be unbounded, no counter logic SHALL exist, and io_timeout SHALL be tied to 0.

Verification
REQ-029 plain: alu_out=16'h1234, rd_addr=5, ird_write_flag=1, szcv_write_flag=1, S/Z/C/V=0/0/1/0 -> next cycle wb_en=1, wb_addr=5, wb_data=16'h1234, szcv=4'b0010.
REQ-030 out: output_flag=1, op_data=16'hBEEF, out_ready held 0 for 3 cycles -> out_valid=1, out_data=16'hBEEF, stall=1 throughout; on out_ready=1 -> IDLE next cycle, with no wb_en.
REQ-031 in: input_flag=1, rd_addr=2, in_valid after 4 cycles with in_data=16'h8000 -> wb_en pulse, wb_addr=2, wb_data=16'h8000, szcv=4'b1000.
REQ-032 priority/halt: halt_flag=1 and output_flag=1 together -> HALTED, halted=1, out_valid stays 0; later flags are ignored until rst_n pulse.
REQ-033 reset mid-IN_WAIT: rst_n=0 while in_ready=1 -> in_ready=0 and stall=0 immediately, with no wb_en.
REQ-034 IO_TIMEOUT_EN, TIMEOUT_CYC=8: output_flag=1 with out_ready=0 -> after 8 cycles back to IDLE with io_timeout=1.

Source files
------------

// File: rtl/io_writeback.sv
// Writeback / I/O stage: commits ALU results, runs IN/OUT device handshakes, and holds HALT.
// Optional IO_TIMEOUT_EN bounds the I/O waits to TIMEOUT_CYC cycles and sets a sticky io_timeout.
module io_writeback #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] alu_out,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        input_flag,
  input  logic        output_flag,
  input  logic        halt_flag,
  input  logic        szcv_write_flag,
  input  logic        ird_write_flag,
  input  logic [2:0]  rd_addr,
  input  logic [15:0] op_data,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [3:0]  szcv,
  output logic        stall,
  output logic        halted,
  output logic        io_timeout
);

  typedef enum logic [1:0] {StIdle, StOutWait, StInWait, StHalted} state_e;

  state_e      state_q, state_d;
  logic        wb_en_q, wb_en_d;
  logic [2:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [3:0]  szcv_q, szcv_d;
  logic [15:0] out_data_q, out_data_d;
  logic [2:0]  in_addr_q, in_addr_d;
  logic        wait_expired;

`ifdef IO_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            io_timeout_q, io_timeout_d;

  // Counter restarts on every wait entry; expires on the TIMEOUT_CYC-th cycle in the wait state.
  always_comb begin
    cnt_d        = '0;
    io_timeout_d = io_timeout_q;
    wait_expired = 1'b0;
    if (state_q == StOutWait || state_q == StInWait) begin
      if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
        wait_expired = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (state_q == StOutWait && wait_expired && !out_ready) io_timeout_d = 1'b1;
    if (state_q == StInWait && wait_expired && !in_valid) io_timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      io_timeout_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  assign io_timeout = io_timeout_q;
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign wait_expired       = 1'b0;
  assign io_timeout         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wb_en_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    szcv_d     = szcv_q;
    out_data_d = out_data_q;
    in_addr_d  = in_addr_q;
    unique case (state_q)
      StIdle: begin
        if (halt_flag) begin
          state_d = StHalted;
        end else if (output_flag) begin
          out_data_d = op_data;
          state_d    = StOutWait;
        end else if (input_flag) begin
          in_addr_d = rd_addr;
          state_d   = StInWait;
        end else begin
          wb_en_d   = ird_write_flag;
          wb_addr_d = rd_addr;
          wb_data_d = alu_out;
          if (szcv_write_flag) szcv_d = {alu_s, alu_z, alu_c, alu_v};
        end
      end
      StOutWait: begin
        if (out_ready || wait_expired) state_d = StIdle;
      end
      StInWait: begin
        if (in_valid) begin
          wb_en_d   = 1'b1;
          wb_addr_d = in_addr_q;
          wb_data_d = in_data;
          szcv_d    = {in_data[15], in_data == 16'h0000, 2'b00};
          state_d   = StIdle;
        end else if (wait_expired) begin
          state_d = StIdle;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= 3'd0;
      wb_data_q  <= 16'h0000;
      szcv_q     <= 4'h0;
      out_data_q <= 16'h0000;
      in_addr_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      szcv_q     <= szcv_d;
      out_data_q <= out_data_d;
      in_addr_q  <= in_addr_d;
    end
  end

  // Handshake strobes decode straight from state so an async reset drops them at once.
  assign stall     = (state_q != StIdle);
  assign in_ready  = (state_q == StInWait);
  assign out_valid = (state_q == StOutWait);
  assign halted    = (state_q == StHalted);
  assign out_data  = out_data_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign szcv      = szcv_q;

endmodule
